// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader.
// Contents:
//   state_e        - loader FSM state encoding (IDLE..ERROR)
//   BYTE_WIDTH     - width of one stream byte
//   BYTES_PER_WORD - payload bytes assembled into one instruction word
//   HDR_BYTES      - header length in bytes (LEN_HI, LEN_LO)
//   LEN_WIDTH      - width of the word count carried in the header
//   csum_add       - modulo-256 checksum accumulate
//   is_loading     - states in which the loader accepts bytes
package inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int LEN_WIDTH      = HDR_BYTES * BYTE_WIDTH;

  // Sum of payload bytes, truncated to 8 bits.
  function automatic logic [BYTE_WIDTH-1:0] csum_add(input logic [BYTE_WIDTH-1:0] acc,
                                                     input logic [BYTE_WIDTH-1:0] b);
    return acc + b;
  endfunction

  // True for the states that consume stream bytes (and count idle time).
  function automatic logic is_loading(input state_e s);
    logic r;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Signals:
//   byte_valid/byte_data/byte_ready - byte stream handshake (transfer when valid & ready)
//   mem_we/mem_address/mem_data     - one-cycle write strobe with address and word
// Modports:
//   master - environment side: drives the byte stream, observes the memory port
//   slave  - loader side: consumes the byte stream, drives the memory port
interface inst_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  import inst_loader_pkg::*;

  logic                  byte_valid;
  logic [BYTE_WIDTH-1:0] byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_address, mem_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_address, mem_data
  );

endinterface

// File: rtl/inst_loader_word_asm.sv
// Byte-to-word assembly and memory write strobe.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   clear        - restart assembly at byte 0 (new load)
//   byte_fire    - a payload byte is accepted this cycle
//   byte_data    - the accepted byte (words arrive MSB first)
//   word_index   - words already written; forms the write address
//   word_last    - the next accepted byte completes a word
//   mem_we/mem_address/mem_data - registered write, high one cycle per word
// The first three bytes of a word sit in a shift register; the completed
// word is copied into a separate output register, so the next word's first
// byte can be accepted in the same cycle the write is presented.
module inst_loader_word_asm
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_fire,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  input  logic [ADDR_WIDTH-1:0] word_index,
  output logic                  word_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data
);

  localparam int SHIFT_W = DATA_WIDTH - BYTE_WIDTH;
  localparam int IDX_W   = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Shift bytes in; on the 4th byte publish the word and its address.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear) begin
      idx_d = {IDX_W{1'b0}};
    end else if (byte_fire) begin
      if (idx_q == LAST_IDX) begin
        we_d   = 1'b1;
        data_d = {shift_q, byte_data};
        addr_d = ADDR_WIDTH'(BASE_ADDR) + word_index;
        idx_d  = {IDX_W{1'b0}};
      end else begin
        shift_d = {shift_q[SHIFT_W-BYTE_WIDTH-1:0], byte_data};
        idx_d   = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Assembly and write-port registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= {IDX_W{1'b0}};
      shift_q <= {SHIFT_W{1'b0}};
      we_q    <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign word_last   = (idx_q == LAST_IDX);
  assign mem_we      = we_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;

endmodule

// File: rtl/inst_loader.sv
// Instruction memory loader: parses a big-endian program image from a byte
// stream (LEN_HI, LEN_LO, 4*N payload bytes, 8-bit payload checksum) and
// writes the words to consecutive addresses starting at BASE_ADDR.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   start        - one-cycle pulse arming a load; ignored while busy
//   bus          - byte stream in, memory write port out (slave modport)
//   busy         - load in progress (LEN_HI..CHECK)
//   done/error   - sticky completion status until the next start
//   word_count   - words written in the current load
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int MEM_WORDS  = 4096,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  inst_loader_if.slave          bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  // Largest N that still ends at or below the top of memory.
  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS - BASE_ADDR);

  state_e                state_q, state_d;
  logic [BYTE_WIDTH-1:0] len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [BYTE_WIDTH-1:0] csum_q, csum_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  fire_s;
  logic                  start_ok_s;
  logic                  timeout_s;
  logic                  asm_fire_s;
  logic                  word_last_s;
  logic [LEN_WIDTH-1:0]  len_in_s;

  assign fire_s     = bus.byte_valid & byte_ready_q;
  assign start_ok_s = start & ~is_loading(state_q);
  assign timeout_s  = is_loading(state_q) & ~fire_s & (idle_q == IDLE_LAST);
  assign asm_fire_s = fire_s & (state_q == ST_DATA);
  assign len_in_s   = {len_hi_q, bus.byte_data};

  // Load sequencing, checksum and word counting; outputs follow the next state.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    words_d  = words_q;
    csum_d   = csum_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          words_d = {LEN_WIDTH{1'b0}};
          csum_d  = {BYTE_WIDTH{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (fire_s) begin
          len_hi_d = bus.byte_data;
          state_d  = ST_LEN_LO;
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (fire_s) begin
          len_d = len_in_s;
          if (32'(len_in_s) > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else if (len_in_s == {LEN_WIDTH{1'b0}}) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (fire_s) begin
          csum_d = csum_add(csum_q, bus.byte_data);
          // The write itself lands next cycle, but CHECK may already
          // accept the checksum byte then.
          if (word_last_s) begin
            words_d = words_q + LEN_WIDTH'(1);
            if ((words_q + LEN_WIDTH'(1)) == len_q) begin
              state_d = ST_CHECK;
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = state_q;
        end
      end
      ST_CHECK: begin
        if (fire_s) begin
          if (bus.byte_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    byte_ready_d = is_loading(state_d);
    busy_d       = is_loading(state_d);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
  end

  // Idle counter: restarts on every accepted byte, runs only while loading.
  always_comb begin
    if (!is_loading(state_q) || fire_s || timeout_s) begin
      idle_d = {IDLE_W{1'b0}};
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= {BYTE_WIDTH{1'b0}};
      len_q        <= {LEN_WIDTH{1'b0}};
      words_q      <= {LEN_WIDTH{1'b0}};
      csum_q       <= {BYTE_WIDTH{1'b0}};
      idle_q       <= {IDLE_W{1'b0}};
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      words_q      <= words_d;
      csum_q       <= csum_d;
      idle_q       <= idle_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  inst_loader_word_asm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_word_asm (
    .clock       (clock),
    .reset       (reset),
    .clear       (start_ok_s),
    .byte_fire   (asm_fire_s),
    .byte_data   (bus.byte_data),
    .word_index  (ADDR_WIDTH'(words_q)),
    .word_last   (word_last_s),
    .mem_we      (bus.mem_we),
    .mem_address (bus.mem_address),
    .mem_data    (bus.mem_data)
  );

  assign bus.byte_ready = byte_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign word_count     = ADDR_WIDTH'(words_q);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed images from the test plan
// plus randomized images, compared against an image-level reference model.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MEMW = 4096;
  localparam int TO   = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [AW-1:0] word_count;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t exp_q[$];

  inst_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  inst_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (0),
    .MEM_WORDS  (MEMW),
    .TIMEOUT    (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write must match the oldest outstanding expected write.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {32'd0, bus.mem_address, bus.mem_data}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("we_addr", bus.mem_address, e.addr);
        check_eq("we_data", bus.mem_data, e.data);
      end
    end
  end

  task automatic check_zero(input string p);
    check_eq({p, "_ready"}, bus.byte_ready, 0);
    check_eq({p, "_we"}, bus.mem_we, 0);
    check_eq({p, "_addr"}, bus.mem_address, 0);
    check_eq({p, "_data"}, bus.mem_data, 0);
    check_eq({p, "_busy"}, busy, 0);
    check_eq({p, "_done"}, done, 0);
    check_eq({p, "_error"}, error, 0);
    check_eq({p, "_wcount"}, word_count, 0);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
  endtask

  // Offer one byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b, input bit with_start);
    int waited;
    waited = 0;
    @(negedge clock);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    start          = with_start;
    while (bus.byte_ready !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check_eq("byte_ready", bus.byte_ready, 1);
    @(posedge clock);
    #1;
    bus.byte_valid = 1'b0;
    start          = 1'b0;
  endtask

  // Load an image and compare writes and final status with the model.
  task automatic run_image(input string tag, input logic [7:0] img[$], input int max_gap,
                           input bit poke_start);
    int         n, nsend;
    logic [7:0] sum;
    bit         oversize, ok;
    wr_t        w;
    n        = int'({img[0], img[1]});
    oversize = (n > MEMW);
    sum      = 8'd0;
    ok       = 1'b0;
    nsend    = 2;
    if (!oversize) begin
      for (int k = 0; k < n; k++) begin
        w.addr = AW'(k);
        w.data = {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]};
        exp_q.push_back(w);
      end
      for (int k = 0; k < 4 * n; k++) sum = sum + img[2+k];
      nsend = 2 + 4 * n + 1;
      ok    = (img[2+4*n] == sum);
    end
    do_start();
    for (int i = 0; i < nsend; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clock);
      send_byte(img[i], poke_start && (i == 4));
    end
    check_eq({tag, "_done"}, done, ok);
    check_eq({tag, "_error"}, error, !ok);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, bus.byte_ready, 0);
    check_eq({tag, "_wcount"}, word_count, oversize ? 0 : n);
    repeat (2) @(posedge clock);
    #1;
    check_eq({tag, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img[$];
    logic [7:0] nominal[$];
    wr_t        w;

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    nominal = '{8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h5E, 8'h43, 8'hA0, 8'h00, 8'h00, 8'h61};

    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Nominal image.
    run_image("nominal", nominal, 0, 1'b0);

    // byte_valid while not busy is not taken.
    @(negedge clock);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (4) begin
      @(posedge clock);
      #1;
      check_eq("idle_ready", bus.byte_ready, 0);
      check_eq("idle_done_sticky", done, 1);
    end
    bus.byte_valid = 1'b0;

    // Bad checksum.
    img = nominal;
    img[10] = 8'h62;
    run_image("badsum", img, 0, 1'b0);

    // Zero length.
    img = '{8'h00, 8'h00, 8'h00};
    run_image("zero", img, 1, 1'b0);

    // Oversize header, N = 4097.
    img = '{8'h10, 8'h01};
    run_image("oversize", img, 0, 1'b0);

    // N = 4096 exactly is accepted; stalling afterwards then times out.
    do_start();
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("maxlen_busy", busy, 1);
    check_eq("maxlen_error", error, 0);
    repeat (TO) @(posedge clock);
    #1;
    check_eq("maxlen_timeout", error, 1);

    // Stall mid-word: error exactly after TO idle cycles.
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    repeat (TO - 1) @(posedge clock);
    #1;
    check_eq("stall_before_to", error, 0);
    @(posedge clock);
    #1;
    check_eq("stall_error", error, 1);
    check_eq("stall_busy", busy, 0);
    check_eq("stall_wcount", word_count, 0);

    // Reset in the middle of DATA, then a clean load.
    w.addr = AW'(0);
    w.data = 32'h2000005E;
    exp_q.push_back(w);
    do_start();
    for (int i = 0; i < 7; i++) send_byte(nominal[i], 1'b0);
    @(negedge clock);
    check_eq("rst_first_written", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    run_image("after_rst", nominal, 0, 1'b0);

    // Randomized images; even runs back-to-back, odd runs with gaps.
    for (int it = 0; it < 8; it++) begin
      int         n;
      logic [7:0] s, b;
      n = $urandom_range(1, 5);
      s = 8'd0;
      img.delete();
      img.push_back(8'(n >> 8));
      img.push_back(8'(n));
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        img.push_back(b);
        s = s + b;
      end
      if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
      img.push_back(s);
      run_image($sformatf("rnd%0d", it), img, (it % 2) * 3, it == 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction ROM interface. Receives a program image as a byte stream (e.g. from a UART receiver) and assembles 32-bit instruction words.
- Writes each word into the instruction memory at consecutive addresses, then reports completion and an error status.
- Sits between the serial byte source and the write port of instruction memory. Lets programs be loaded without re-synthesising the ROM contents.

Parameters:
- ADDR_WIDTH, 12, instruction memory address width.
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes per word.
- BASE_ADDR, 0, address of the first word written.
- MEM_WORDS, 4096, memory depth; the load must end at or below this.
- TIMEOUT, 1000000, maximum idle clocks between bytes while busy.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a load; ignored while busy.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  incoming byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_address  out  ADDR_WIDTH  write address.
- mem_data  out  DATA_WIDTH  write data.
- busy  out  1  high from start accepted until DONE or ERROR is entered.
- done  out  1  high while in DONE state.
- error  out  1  high while in ERROR state.
- word_count  out  ADDR_WIDTH  number of words written so far.

Behaviour:
- Reset: every output is 0; state is IDLE; internal counters and the checksum are 0. Reset asserted mid-load aborts immediately; words already written stay in memory.
- Image format, big-endian:
  - LEN_HI byte, then LEN_LO byte, giving N = {LEN_HI, LEN_LO}.
  - 4*N payload bytes, each word sent MSB first.
  - One checksum byte equal to the sum mod 256 of all payload bytes. Header bytes are excluded from the sum.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
  - IDLE: byte_ready=0. On start go to LEN_HI, clear word_count, clear checksum, and set busy=1.
  - LEN_HI: accept 1 byte, then go to LEN_LO.
  - LEN_LO: accept 1 byte, then check N.
    - N > MEM_WORDS - BASE_ADDR: go to ERROR.
    - N == 0: go to CHECK.
    - Otherwise: go to DATA.
  - DATA: shift each accepted byte into a 32-bit assembly register and add it to the checksum. When the 4th byte of a word is accepted, mem_we goes high on the next cycle for exactly 1 cycle:
    - mem_address = BASE_ADDR + word_count and mem_data = the assembled word, both valid in that cycle.
    - word_count increments in that same cycle.
    - byte_ready stays high, so back-to-back bytes are allowed. The register is double-buffered so the next word's first byte is never lost.
    - After word N has been written, go to CHECK.
  - CHECK: accept 1 byte. Equal to the checksum: go to DONE. Otherwise: go to ERROR.
  - DONE and ERROR: byte_ready=0 and busy=0. The state is sticky until the next start pulse, which restarts at LEN_HI and clears done and error.
- Timeout: an idle counter resets on every accepted byte and counts cycles in LEN_HI, LEN_LO, DATA and CHECK. Reaching TIMEOUT forces ERROR.
- start asserted while busy: ignored.
- byte_valid while not busy: not accepted, since byte_ready=0.
- mem_address never wraps. This is guaranteed by the length check.
- Latency: last payload byte accepted in cycle t means the final mem_we is in t+1. The checksum byte is accepted from t+1 onward, and done rises one cycle after the checksum byte is accepted.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..ERROR);
  - BYTES_PER_WORD = 4;
  - the image header layout constants.
- Natural sub-module: inst_loader_word_asm, which performs byte-to-word assembly and the write strobe. The FSM, checksum, counters and timeout stay in the top block.

Test Plan:
- Nominal load: start, then bytes 00 02 20 00 00 5E 43 A0 00 00 61.
  - Expect mem_we twice: address 0 with data 0x2000005E, then address 1 with data 0x43A00000.
  - Then done=1, error=0, word_count=2.
- Bad checksum: same image with final byte 62.
  - Expect both writes, then error=1 and done=0.
- Zero length: 00 00 00.
  - Expect no mem_we, then done=1.
- Oversize: header 10 01 (N=4097) with BASE_ADDR=0.
  - Expect error=1 right after LEN_LO and no mem_we.
- Stall and timeout: with TIMEOUT=16, send 00 01 20, then hold byte_valid=0 for 16 cycles.
  - Expect error=1 and busy=0.
- Reset mid-DATA, then a fresh start and the nominal image.
  - Expect all outputs 0 after reset, then a clean load ending in done=1.
- Back-to-back bytes with no gaps: expect no byte dropped and correct data at each write.
